// File: rtl/bus_fabric_pkg.sv
// bus_fabric_pkg: shared FSM states and field-width constants for mem_bus_fabric
package bus_fabric_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [31:0] ERR_DATA_DEF = 32'hBADADD00;
  localparam int SLV_AW = 16;
  localparam int SLV_WW = 4;
  localparam int DW = 32;
  localparam int CNT_W = 8;
endpackage

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: combinational priority address decoder, lowest slave index wins on overlap
module bus_addr_decode
  import bus_fabric_pkg::*;
#(
  parameter int N_SLAVES = 6,
  parameter int DEC_BITS = 16,
  parameter logic [SLV_AW*N_SLAVES-1:0] SLV_BASE = '0,
  parameter logic [SLV_AW*N_SLAVES-1:0] SLV_MASK = {N_SLAVES{16'hF000}},
  parameter int SW = 3
) (
  input  logic [DW-1:0] addr_i,
  output logic          hit_o,
  output logic [SW-1:0] sel_o
);
  localparam logic [DW-1:0] DMASK = DEC_BITS >= DW ? '1 : (DW'(1) << DEC_BITS) - DW'(1);
  // scan from the top down so the lowest matching index is the one left standing
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--)
      if ((addr_i & DMASK & DW'(SLV_MASK[SLV_AW*i +: SLV_AW])) == (DW'(SLV_BASE[SLV_AW*i +: SLV_AW]) & DMASK)) begin
        hit_o = 1'b1;
        sel_o = SW'(i);
      end
  end
endmodule

// File: rtl/mem_bus_fabric.sv
// mem_bus_fabric: picorv32 native-bus interconnect with registered ready/rdata; optional BUS_FABRIC_TIMEOUT_EN aborts hung accesses
module mem_bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int N_SLAVES = 6,
  parameter int DEC_BITS = 16,
  parameter logic [SLV_AW*N_SLAVES-1:0] SLV_BASE = '0,
  parameter logic [SLV_AW*N_SLAVES-1:0] SLV_MASK = {N_SLAVES{16'hF000}},
  parameter logic [SLV_WW*N_SLAVES-1:0] SLV_WAIT = {N_SLAVES{4'd1}},
  parameter int TIMEOUT = 255,
  parameter logic [DW-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m_valid,
  input  logic [DW-1:0]          m_addr,
  input  logic [DW-1:0]          m_wdata,
  input  logic [3:0]             m_wstrb,
  output logic                   m_ready,
  output logic [DW-1:0]          m_rdata,
  output logic [N_SLAVES-1:0]    s_valid,
  output logic [DW-1:0]          s_addr,
  output logic [DW-1:0]          s_wdata,
  output logic [4*N_SLAVES-1:0]  s_wstrb,
  input  logic [N_SLAVES-1:0]    s_ready,
  input  logic [DW*N_SLAVES-1:0] s_rdata,
  output logic                   bus_err,
  output logic [DW-1:0]          err_addr
);
  localparam int SW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1;
`ifdef BUS_FABRIC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  state_t               state_q;
  logic [SW-1:0]        sel_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [N_SLAVES-1:0]  s_valid_q;
  logic                 m_ready_q;
  logic                 bus_err_q;
  logic [DW-1:0]        m_rdata_q;
  logic [DW-1:0]        err_addr_q;
  logic                 hit;
  logic [SW-1:0]        dec_sel;
  logic [SLV_WW-1:0]    wait_sel;
  logic                 done_ok;
  logic                 to_hit;
  bus_addr_decode #(
    .N_SLAVES(N_SLAVES),
    .DEC_BITS(DEC_BITS),
    .SLV_BASE(SLV_BASE),
    .SLV_MASK(SLV_MASK),
    .SW(SW)
  ) u_dec (
    .addr_i(m_addr),
    .hit_o(hit),
    .sel_o(dec_sel)
  );
  assign wait_sel = SLV_WAIT[SLV_WW*int'(sel_q) +: SLV_WW];
  assign done_ok = wait_sel == '0 ? s_ready[sel_q] : cnt_q == CNT_W'(wait_sel);
  assign to_hit = TO_EN && cnt_q == CNT_W'(TIMEOUT);
  assign m_ready = m_ready_q;
  assign bus_err = bus_err_q;
  assign m_rdata = m_rdata_q;
  assign err_addr = err_addr_q;
  assign s_valid = s_valid_q;
  assign s_addr = m_addr;
  assign s_wdata = m_wdata;
  for (genvar g = 0; g < N_SLAVES; g++) begin : g_wstrb
    assign s_wstrb[4*g +: 4] = s_valid_q[g] ? m_wstrb : 4'h0;
  end
  // request FSM: decode in IDLE, wait/ready/timeout in ACCESS, single completion pulse in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      s_valid_q  <= '0;
      m_ready_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      m_rdata_q  <= '0;
      err_addr_q <= '0;
    end else begin
      m_ready_q <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: if (m_valid) begin
          if (hit) begin
            sel_q     <= dec_sel;
            cnt_q     <= '0;
            s_valid_q <= N_SLAVES'(1) << dec_sel;
            state_q   <= ACCESS;
          end else begin
            m_rdata_q  <= ERR_DATA;
            err_addr_q <= m_addr;
            m_ready_q  <= 1'b1;
            bus_err_q  <= 1'b1;
            state_q    <= DONE;
          end
        end
        ACCESS: if (!m_valid) begin
          s_valid_q <= '0;
          state_q   <= IDLE;
        end else if (done_ok) begin
          m_rdata_q <= s_rdata[DW*int'(sel_q) +: DW];
          m_ready_q <= 1'b1;
          s_valid_q <= '0;
          state_q   <= DONE;
        end else if (to_hit) begin
          m_rdata_q  <= ERR_DATA;
          err_addr_q <= m_addr;
          m_ready_q  <= 1'b1;
          bus_err_q  <= 1'b1;
          s_valid_q  <= '0;
          state_q    <= DONE;
        end else begin
          cnt_q <= cnt_q + CNT_W'(cnt_q != '1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_fabric.sv
// tb_mem_bus_fabric: randomized transaction-level check of mem_bus_fabric against a latency/decode model
module tb_mem_bus_fabric;
  localparam int N = 6;
  localparam int TO = 8;
  localparam logic [16*N-1:0] BASE = {16'h4000, 16'h3000, 16'h2000, 16'h1000, 16'h1000, 16'h0000};
  localparam logic [16*N-1:0] MASK = {N{16'hF000}};
  localparam logic [4*N-1:0] WAITS = {4'd0, 4'd3, 4'd0, 4'd0, 4'd2, 4'd1};
  localparam logic [31:0] ERRD = 32'hBADADD00;
`ifdef BUS_FABRIC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_valid = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0] m_wstrb = '0;
  logic m_ready;
  logic [31:0] m_rdata;
  logic [N-1:0] s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [4*N-1:0] s_wstrb;
  logic [N-1:0] s_ready = '0;
  logic [32*N-1:0] s_rdata = '0;
  logic bus_err;
  logic [31:0] err_addr;
  int checks = 0;
  int failures = 0;
  logic [31:0] last_err = '0;
  logic [15:0] sb [N] = '{16'h0000, 16'h1000, 16'h1000, 16'h2000, 16'h3000, 16'h4000};
  int sw [N] = '{1, 2, 0, 0, 3, 0};

  mem_bus_fabric #(
    .N_SLAVES(N),
    .DEC_BITS(16),
    .SLV_BASE(BASE),
    .SLV_MASK(MASK),
    .SLV_WAIT(WAITS),
    .TIMEOUT(TO),
    .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata), .s_valid(s_valid),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready),
    .s_rdata(s_rdata), .bus_err(bus_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a[15:0] & 16'hF000) == sb[i]) return i;
    return -1;
  endfunction

  function automatic logic [4*N-1:0] strb_of(input logic [N-1:0] sv, input logic [3:0] ws);
    logic [4*N-1:0] r = '0;
    for (int i = 0; i < N; i++) if (sv[i]) r[4*i +: 4] = ws;
    return r;
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) s_rdata[32*i +: 32] = $urandom;
    m_valid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws; s_ready = '0;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input int d, input bit all_junk);
    int s, dc;
    bit err;
    logic [N-1:0] esv;
    logic [31:0] erd;
    start(a, wd, ws);
    s = decode(a);
    if (s < 0) begin dc = 1; err = 1'b1; end
    else if (sw[s] != 0) begin err = TO_EN && sw[s] > TO; dc = err ? TO + 2 : sw[s] + 2; end
    else begin err = TO_EN && d > TO; dc = err ? TO + 2 : d + 2; end
    erd = err ? ERRD : s_rdata[32*s +: 32];
    for (int k = 1; k <= dc; k++) begin
      @(posedge clk); #1;
      s_ready = all_junk ? '1 : N'($urandom);
      if (s >= 0 && sw[s] == 0) s_ready[s] = (k == d + 1);
      @(negedge clk);
      esv = (s >= 0 && k < dc) ? N'(1) << s : '0;
      chk("s_valid", 64'(s_valid), 64'(esv));
      chk("s_wstrb", 64'(s_wstrb), 64'(strb_of(esv, ws)));
      chk("ready_err", {m_ready, bus_err}, k == dc ? {1'b1, err} : 2'b00);
    end
    if (err) last_err = a;
    chk("m_rdata", m_rdata, erd);
    chk("err_addr", err_addr, last_err);
    chk("s_addr_wdata", {s_addr, s_wdata}, {a, wd});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    m_valid = 1'b0; m_wstrb = '0; s_ready = '0;
    @(negedge clk);
    chk("idle", {m_ready, bus_err, s_valid}, '0);
  endtask

  task automatic abort(input logic [31:0] a, input int h);
    int s;
    start(a, 32'h0, 4'h3);
    s = decode(a);
    for (int k = 1; k <= h + 2; k++) begin
      @(posedge clk); #1;
      s_ready = '0;
      if (k == h + 1) begin m_valid = 1'b0; m_wstrb = '0; end
      @(negedge clk);
      chk("abort_sv", 64'(s_valid), k <= h + 1 ? 64'(N'(1) << s) : 64'h0);
      chk("abort_rdy", {m_ready, bus_err}, 2'b00);
    end
  endtask

  task automatic mid_reset();
    start(32'h0000_3000, 32'h0, 4'h0);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre_rst_sv", 64'(s_valid), 64'(N'(1) << 4));
    end
    #1 rst_n = 1'b0; m_valid = 1'b0;
    #1;
    chk("rst_async", {m_ready, bus_err, s_valid, s_wstrb}, '0);
    chk("rst_err_addr", err_addr, 32'h0);
    last_err = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int nib;
    repeat (3) @(negedge clk);
    chk("reset_out", {m_ready, bus_err, s_valid, s_wstrb}, '0);
    chk("reset_data", {m_rdata, err_addr}, 64'h0);
    rst_n = 1'b1;
    run(32'h0000_0100, 32'h0, 4'h0, 0, 1'b0);
    run(32'h0000_4000, 32'hCAFE_F00D, 4'b0001, 3, 1'b0);
    run(32'h0000_9000, 32'h0, 4'h0, 0, 1'b0);
    run(32'h0000_4000, 32'h0, 4'h0, 30, 1'b0);
    run(32'h0000_1000, 32'h1111_2222, 4'hF, 0, 1'b1);
    run(32'h0000_2004, 32'h0, 4'h0, 0, 1'b0);
    run(32'h0000_2008, 32'h0, 4'h0, TO, 1'b0);
    run(32'hFFFF_0ABC, 32'h0, 4'h0, 0, 1'b0);
    run(32'h0000_F000, 32'h55AA_55AA, 4'hF, 0, 1'b0);
    idle();
    abort(32'h0000_4010, 3);
    abort(32'h0000_3010, 2);
    mid_reset();
    run(32'h0000_3020, 32'h0, 4'h0, 0, 1'b0);
    for (int t = 0; t < 200; t++) begin
      nib = $urandom_range(0, 7);
      a = $urandom;
      a[15:12] = nib < 5 ? 4'(nib) : 4'(5 + $urandom_range(0, 10));
      run(a, $urandom, $urandom_range(0, 1) ? 4'($urandom) : 4'h0, $urandom_range(0, 12), 1'b0);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
